// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Display timing source for the VGA path.  One clk = one pixel.  This block
// produces:
//   - the pixel column/row counters that drive the map, icon and welcome/victory
//     ROM lookups
//   - video_on, which marks the visible area
//   - line_start and frame_start, the start-of-line and start-of-frame pulses
//   - horiz_sync/vert_sync, delayed by PIPE_DLY clocks so that they line up
//     with RGB leaving the registered colorizer
//
// Ports
//   clk           in   1   pixel clock (only clock)
//   reset_n       in   1   asynchronous active-low reset
//   en            in   1   count enable; low holds all state
//   pixel_column  out  10  horizontal count, 0..H_TOTAL-1
//   pixel_row     out  10  vertical count, 0..V_TOTAL-1
//   video_on      out  1   column < H_ACTIVE and row < V_ACTIVE
//   line_start    out  1   one-clock pulse when the column is 0
//   frame_start   out  1   one-clock pulse when the column and row are both 0
//   horiz_sync    out  1   hsync at level SYNC_POL when asserted, PIPE_DLY late
//   vert_sync     out  1   vsync at level SYNC_POL when asserted, PIPE_DLY late
//   frame_count   out  16  frames completed
//
// Configuration macro
//   FRAME_COUNT_EN  When this macro is defined, frame_count counts wraps to
//                   (0,0) modulo 2^16.  When it is undefined, the port is tied
//                   to 16'd0 and no counter flops exist.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [9:0]  pixel_column,
    output logic [9:0]  pixel_row,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic        horiz_sync,
    output logic        vert_sync,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_W  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_W  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       video_q, video_d;
    logic       line_q, line_d;
    logic       frame_q, frame_d;
    logic       hraw_q, hraw_d;
    logic       vraw_q, vraw_d;
    logic       wrap_s;

    // Next count: the column wraps at the end of each line, and the row wraps at the end of each frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (en) begin
            if (col_q == H_LAST) begin
                col_d = 10'd0;
                if (row_q == V_LAST) begin
                    row_d = 10'd0;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Flags are decoded from the next count, so they register alongside it with zero skew.
    always_comb begin
        video_d = (col_d < H_ACT_W) && (row_d < V_ACT_W);
        line_d  = (col_d == 10'd0);
        frame_d = (col_d == 10'd0) && (row_d == 10'd0);
        hraw_d  = ((col_d >= HS_START) && (col_d < HS_END)) ? SYNC_ON : SYNC_OFF;
        vraw_d  = ((row_d >= VS_START) && (row_d < VS_END)) ? SYNC_ON : SYNC_OFF;
        wrap_s  = en && (col_q == H_LAST) && (row_q == V_LAST);
    end

    // Counter and flag registers.  Start pulses drop on held clocks so that a pulse never stretches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q   <= 10'd0;
            row_q   <= 10'd0;
            video_q <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            hraw_q  <= SYNC_OFF;
            vraw_q  <= SYNC_OFF;
        end else if (en) begin
            col_q   <= col_d;
            row_q   <= row_d;
            video_q <= video_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            hraw_q  <= hraw_d;
            vraw_q  <= vraw_d;
        end else begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end
    end

    assign pixel_column = col_q;
    assign pixel_row    = row_q;
    assign video_on     = video_q;
    assign line_start   = line_q;
    assign frame_start  = frame_q;

    // Sync delay line that matches the colorizer pipeline.  It advances only on enabled clocks.
    generate
        if (PIPE_DLY == 0) begin : g_no_pipe
            assign horiz_sync = hraw_q;
            assign vert_sync  = vraw_q;
        end else if (PIPE_DLY == 1) begin : g_pipe1
            logic hpipe_q;
            logic vpipe_q;

            // Single-stage sync delay.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hpipe_q <= SYNC_OFF;
                    vpipe_q <= SYNC_OFF;
                end else if (en) begin
                    hpipe_q <= hraw_q;
                    vpipe_q <= vraw_q;
                end else begin
                    hpipe_q <= hpipe_q;
                    vpipe_q <= vpipe_q;
                end
            end

            assign horiz_sync = hpipe_q;
            assign vert_sync  = vpipe_q;
        end else begin : g_pipeN
            logic [PIPE_DLY-1:0] hpipe_q;
            logic [PIPE_DLY-1:0] vpipe_q;

            // Multi-stage sync delay.  Bit 0 is the youngest stage.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    hpipe_q <= {PIPE_DLY{SYNC_OFF}};
                    vpipe_q <= {PIPE_DLY{SYNC_OFF}};
                end else if (en) begin
                    hpipe_q <= {hpipe_q[PIPE_DLY-2:0], hraw_q};
                    vpipe_q <= {vpipe_q[PIPE_DLY-2:0], vraw_q};
                end else begin
                    hpipe_q <= hpipe_q;
                    vpipe_q <= vpipe_q;
                end
            end

            assign horiz_sync = hpipe_q[PIPE_DLY-1];
            assign vert_sync  = vpipe_q[PIPE_DLY-1];
        end
    endgenerate

`ifdef FRAME_COUNT_EN
    logic [15:0] fcount_q;

    // Frames completed: the counter advances on each wrap to (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcount_q <= 16'd0;
        end else if (wrap_s) begin
            fcount_q <= fcount_q + 16'd1;
        end else begin
            fcount_q <= fcount_q;
        end
    end

    assign frame_count = fcount_q;
`else
    logic unused_wrap_s;
    assign unused_wrap_s = wrap_s;
    assign frame_count   = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    // Reduced timing so that several whole frames fit in a short run.
    localparam int HA = 20, HF = 4, HS = 6, HB = 5;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 35
    localparam int VT = VA + VF + VS + VB;   // 19
    localparam int FR = HT * VT;             // 665

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;

    logic [9:0]  a_col, a_row, b_col, b_row;
    logic        a_vid, a_ls, a_fs, a_hs, a_vs;
    logic        b_vid, b_ls, b_fs, b_hs, b_vs;
    logic [15:0] a_fc, b_fc;

    always #20 clk = ~clk;

    // DUT A: active-low syncs, one-clock delay.
    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIPE_DLY(1)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .en(en),
        .pixel_column(a_col), .pixel_row(a_row), .video_on(a_vid),
        .line_start(a_ls), .frame_start(a_fs),
        .horiz_sync(a_hs), .vert_sync(a_vs), .frame_count(a_fc)
    );

    // DUT B: active-high syncs, three-clock delay.
    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .PIPE_DLY(3)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .en(en),
        .pixel_column(b_col), .pixel_row(b_row), .video_on(b_vid),
        .line_start(b_ls), .frame_start(b_fs),
        .horiz_sync(b_hs), .vert_sync(b_vs), .frame_count(b_fc)
    );

    typedef struct packed {
        logic [9:0]  col;
        logic [9:0]  row;
        logic        vid;
        logic        ls;
        logic        fs;
        logic        hs_a;
        logic        vs_a;
        logic        hs_b;
        logic        vs_b;
        logic [15:0] fc;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.  The sync bits hold "asserted" (1) rather than the pin level.
    int         m_col, m_row;
    logic       m_vid, m_ls, m_fs, m_hraw, m_vraw;
    logic [3:0] m_hp, m_vp;
    logic [15:0] m_fc;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0;
        m_vid = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
        m_hraw = 1'b0; m_vraw = 1'b0;
        m_hp = 4'd0; m_vp = 4'd0;
        m_fc = 16'd0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic en_v);
        int nc, nr;
        if (en_v) begin
            nc = m_col + 1;
            nr = m_row;
            if (nc == HT) begin
                nc = 0;
                nr = m_row + 1;
                if (nr == VT) begin
                    nr = 0;
`ifdef FRAME_COUNT_EN
                    m_fc = m_fc + 16'd1;
`endif
                end
            end
            m_hp   = {m_hp[2:0], m_hraw};
            m_vp   = {m_vp[2:0], m_vraw};
            m_col  = nc;
            m_row  = nr;
            m_vid  = (nc < HA) && (nr < VA);
            m_ls   = (nc == 0);
            m_fs   = (nc == 0) && (nr == 0);
            m_hraw = (nc >= HA + HF) && (nc < HA + HF + HS);
            m_vraw = (nr >= VA + VF) && (nr < VA + VF + VS);
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.col  = 10'(m_col);
        e.row  = 10'(m_row);
        e.vid  = m_vid;
        e.ls   = m_ls;
        e.fs   = m_fs;
        e.hs_a = ~m_hp[0];
        e.vs_a = ~m_vp[0];
        e.hs_b = m_hp[2];
        e.vs_b = m_vp[2];
        e.fc   = m_fc;
        return e;
    endfunction

    // One clock: drive en and push the expectation, then pop it and compare after the edge.
    task automatic step(input logic en_v);
        exp_t e;
        @(negedge clk);
        en = en_v;
        model_step(en_v);
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("col",   a_col, e.col);
            check_val("row",   a_row, e.row);
            check_val("video", a_vid, e.vid);
            check_val("lstart", a_ls, e.ls);
            check_val("fstart", a_fs, e.fs);
            check_val("hsync_a", a_hs, e.hs_a);
            check_val("vsync_a", a_vs, e.vs_a);
            check_val("col_b", b_col, e.col);
            check_val("hsync_b", b_hs, e.hs_b);
            check_val("vsync_b", b_vs, e.vs_b);
            check_val("fcount", a_fc, e.fc);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_col"}, a_col, 32'd0);
        check_val({tag, "_row"}, a_row, 32'd0);
        check_val({tag, "_vid"}, a_vid, 32'd0);
        check_val({tag, "_ls"},  a_ls,  32'd0);
        check_val({tag, "_fs"},  a_fs,  32'd0);
        check_val({tag, "_hs_a"}, a_hs, 32'd1);
        check_val({tag, "_vs_a"}, a_vs, 32'd1);
        check_val({tag, "_hs_b"}, b_hs, 32'd0);
        check_val({tag, "_vs_b"}, b_vs, 32'd0);
        check_val({tag, "_fc"},  a_fc,  32'd0);
    endtask

    initial begin
        int first_fs;
        int guard;

        // Power-on reset.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset_n = 1'b1;

        // First frame plus a bit, fully enabled.
        for (int i = 0; i < FR + 50; i++) step(1'b1);

        // Move to column 10, hold for 7 clocks, then resume.
        guard = 0;
        while (m_col != 10 && guard < FR) begin
            step(1'b1);
            guard++;
        end
        check_val("seek_col10", a_col, 32'd10);
        for (int i = 0; i < 7; i++) step(1'b0);
        check_val("hold_col", a_col, 32'd10);
        step(1'b1);
        check_val("resume_col", a_col, 32'd11);

        // Random enable for about a frame and a half.
        for (int i = 0; i < FR + 300; i++) step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

        // Mid-frame reset that asserts between clock edges.
        guard = 0;
        while (!(m_row == 5 && m_col == 17) && guard < 2 * FR) begin
            step(1'b1);
            guard++;
        end
        check_val("seek_mid", a_row, 32'd5);
        #5;
        reset_n = 1'b0;
        #2;
        check_reset_state("async");
        @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;

        // The next frame_start appears one full frame after release.
        first_fs = -1;
        for (int k = 1; k <= FR + 5; k++) begin
            step(1'b1);
            if (k == 1) check_val("first_col", a_col, 32'd1);
            if (a_fs && first_fs < 0) first_fs = k;
        end
        check_val("fs_after_rst", first_fs, FR);

        // Exactly five whole frames from a fresh reset.
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5 * FR; i++) step(1'b1);
`ifdef FRAME_COUNT_EN
        check_val("fc_5", a_fc, 32'd5);
`else
        check_val("fc_0", a_fc, 32'd0);
`endif
        check_val("fc_b", b_fc, a_fc);
        check_val("end_col", a_col, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
